// File: rtl/vme_dtack_ctrl.sv
// VME data-transfer acknowledge controller.
// Sits behind the address/strobe decoder: pulses a start strobe to the
// addressed device, waits for its acknowledge, and answers the VME master
// with DTACK_B (device done) or BERR_B (timeout / unmapped device).
// The bus response is held until the master releases its data strobe.
// Failed cycles (timeouts, unmapped devices, master aborts) are counted in a
// saturating diagnostic counter.
module vme_dtack_ctrl #(
   parameter int TIMEOUT = 64,   // WAIT cycles allowed before bus error, 2..255
   parameter int ERRW    = 8     // error counter width
) (
   input  logic            FASTCLK,
   input  logic            RST_B,
   input  logic            VMEREADY,
   input  logic            STROBE,
   input  logic            STRBCE,
   input  logic [9:0]      DEVICE,
   input  logic [9:0]      COMMAND,
   input  logic            WRITE_B,
   input  logic [9:0]      DEV_ACK,
   output logic [9:0]      DEV_STRB,
   output logic [9:0]      CMD,
   output logic            WR_B,
   output logic            DTACK_B,
   output logic            BERR_B,
   output logic            BUSY,
   output logic [ERRW-1:0] ERRCNT
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_ACK   = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   // Last timer value tolerated in WAIT; reaching it without an ack is a timeout.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t          state_q;
   logic [9:0]      dev_l_q;
   logic [7:0]      timer_q;
   logic [9:0]      dev_strb_q;
   logic [9:0]      cmd_q;
   logic            wr_b_q;
   logic            dtack_b_q;
   logic            berr_b_q;
   logic            busy_q;
   logic [ERRW-1:0] errcnt_q;

   logic            ack_hit_s;
   logic            tmo_hit_s;

   // Saturating increment: the counter sticks at all-ones instead of wrapping.
   function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
      if (&v) begin
         return v;
      end else begin
         return v + ERRW'(1);
      end
   endfunction

   // Only the acknowledge bit of the latched device is honoured.
   assign ack_hit_s = |(DEV_ACK & dev_l_q);
   assign tmo_hit_s = (timer_q == TMO_LAST);

   // Cycle sequencer: state, latched request, timer, bus response and error count.
   always_ff @(posedge FASTCLK or negedge RST_B) begin
      if (!RST_B) begin
         state_q    <= S_IDLE;
         dev_l_q    <= 10'd0;
         timer_q    <= 8'd0;
         dev_strb_q <= 10'd0;
         cmd_q      <= 10'd0;
         wr_b_q     <= 1'b1;
         dtack_b_q  <= 1'b1;
         berr_b_q   <= 1'b1;
         busy_q     <= 1'b0;
         errcnt_q   <= '0;
      end else begin
         // Response lines follow the state one edge late, so each stays
         // asserted for the edge on which the FSM leaves ACK/ERR.
         dev_strb_q <= 10'd0;
         dtack_b_q  <= (state_q != S_ACK);
         berr_b_q   <= (state_q != S_ERR);

         case (state_q)
            S_IDLE: begin
               if (STRBCE && VMEREADY) begin
                  dev_l_q <= DEVICE;
                  cmd_q   <= COMMAND;
                  wr_b_q  <= WRITE_B;
                  busy_q  <= 1'b1;
                  if (DEVICE == 10'd0) begin
                     state_q  <= S_ERR;
                     errcnt_q <= sat_inc(errcnt_q);
                  end else begin
                     state_q <= S_ISSUE;
                  end
               end else begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end

            S_ISSUE: begin
               timer_q <= 8'd0;
               if (!STROBE) begin
                  // Master gave up before the device was started.
                  state_q  <= S_IDLE;
                  busy_q   <= 1'b0;
                  errcnt_q <= sat_inc(errcnt_q);
               end else begin
                  dev_strb_q <= dev_l_q;
                  state_q    <= S_WAIT;
                  busy_q     <= 1'b1;
               end
            end

            S_WAIT: begin
               if (!STROBE) begin
                  // Abort wins over a same-edge acknowledge.
                  state_q  <= S_IDLE;
                  busy_q   <= 1'b0;
                  errcnt_q <= sat_inc(errcnt_q);
               end else if (ack_hit_s) begin
                  // Acknowledge wins over a same-edge timeout.
                  state_q <= S_ACK;
                  busy_q  <= 1'b1;
               end else if (tmo_hit_s) begin
                  state_q  <= S_ERR;
                  busy_q   <= 1'b1;
                  errcnt_q <= sat_inc(errcnt_q);
               end else begin
                  state_q <= S_WAIT;
                  busy_q  <= 1'b1;
                  timer_q <= timer_q + 8'd1;
               end
            end

            S_ACK: begin
               if (!STROBE) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= S_ACK;
                  busy_q  <= 1'b1;
               end
            end

            S_ERR: begin
               if (!STROBE) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= S_ERR;
                  busy_q  <= 1'b1;
               end
            end

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign DEV_STRB = dev_strb_q;
   assign CMD      = cmd_q;
   assign WR_B     = wr_b_q;
   assign DTACK_B  = dtack_b_q;
   assign BERR_B   = berr_b_q;
   assign BUSY     = busy_q;
   assign ERRCNT   = errcnt_q;

endmodule

// File: tb/tb_vme_dtack_ctrl.sv
// Scoreboard bench for vme_dtack_ctrl (TIMEOUT=4, ERRW=8).
// Stimulus pushes the expected output events (strobe pulse, DTACK/BERR edges,
// counter changes) with the edge number they must appear on; a monitor on the
// falling clock edge detects events on the DUT outputs and pops/compares.
module tb_vme_dtack_ctrl;

   localparam int TO   = 4;
   localparam int EV_STRB  = 0;
   localparam int EV_DTACK = 1;
   localparam int EV_BERR  = 2;
   localparam int EV_CNT   = 3;

   logic       FASTCLK = 1'b0;
   logic       RST_B   = 1'b0;
   logic       VMEREADY = 1'b1;
   logic       STROBE  = 1'b0;
   logic       STRBCE  = 1'b0;
   logic [9:0] DEVICE  = 10'd0;
   logic [9:0] COMMAND = 10'd0;
   logic       WRITE_B = 1'b1;
   logic [9:0] DEV_ACK = 10'd0;
   logic [9:0] DEV_STRB;
   logic [9:0] CMD;
   logic       WR_B;
   logic       DTACK_B;
   logic       BERR_B;
   logic       BUSY;
   logic [7:0] ERRCNT;

   typedef struct {
      int          kind;
      int          cyc;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   total  = 0;
   int   bad    = 0;
   bit   mon_en = 1'b0;
   logic dtack_p = 1'b1;
   logic berr_p  = 1'b1;
   logic [7:0] cnt_p = 8'd0;
   int   cnt_model = 0;
   int   e;

   vme_dtack_ctrl #(.TIMEOUT(TO), .ERRW(8)) dut (
      .FASTCLK (FASTCLK),
      .RST_B   (RST_B),
      .VMEREADY(VMEREADY),
      .STROBE  (STROBE),
      .STRBCE  (STRBCE),
      .DEVICE  (DEVICE),
      .COMMAND (COMMAND),
      .WRITE_B (WRITE_B),
      .DEV_ACK (DEV_ACK),
      .DEV_STRB(DEV_STRB),
      .CMD     (CMD),
      .WR_B    (WR_B),
      .DTACK_B (DTACK_B),
      .BERR_B  (BERR_B),
      .BUSY    (BUSY),
      .ERRCNT  (ERRCNT)
   );

   initial forever #5 FASTCLK = ~FASTCLK;

   always @(posedge FASTCLK) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: sim time expired, got no summary, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int k, input int c, input logic [31:0] d);
      exp_t x;
      x.kind = k;
      x.cyc  = c;
      x.data = d;
      sb.push_back(x);
   endtask

   task automatic observe(input int k, input logic [31:0] d);
      exp_t x;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL unexpected_event: got kind=%0d edge=%0d data=%0h, required none", k, cyc, d);
      end else begin
         x = sb.pop_front();
         if (x.kind != k || x.cyc != cyc || x.data !== d) begin
            bad++;
            $display("FAIL event: got kind=%0d edge=%0d data=%0h, required kind=%0d edge=%0d data=%0h",
                     k, cyc, d, x.kind, x.cyc, x.data);
         end
      end
   endtask

   // Monitor: turn output activity into events and compare against the scoreboard.
   always @(negedge FASTCLK) begin
      if (mon_en) begin
         if (DEV_STRB != 10'd0) observe(EV_STRB, {11'd0, WR_B, CMD, DEV_STRB});
         if (DTACK_B !== dtack_p) observe(EV_DTACK, {31'd0, DTACK_B});
         if (BERR_B !== berr_p) observe(EV_BERR, {31'd0, BERR_B});
         if (ERRCNT !== cnt_p) observe(EV_CNT, {24'd0, ERRCNT});
         if (!DTACK_B && !BERR_B) begin
            total++;
            bad++;
            $display("FAIL both_low: got DTACK_B=0 BERR_B=0 at edge %0d, required not both low", cyc);
         end
      end
      dtack_p <= DTACK_B;
      berr_p  <= BERR_B;
      cnt_p   <= ERRCNT;
   end

   task automatic to_edge(input int n);
      while (cyc < n) @(negedge FASTCLK);
   endtask

   // Present a cycle start sampled on the next rising edge, then drop STRBCE.
   task automatic drive_start(input logic [9:0] dev, input logic [9:0] cmd, input logic wrb);
      STROBE  = 1'b1;
      STRBCE  = 1'b1;
      DEVICE  = dev;
      COMMAND = cmd;
      WRITE_B = wrb;
      @(negedge FASTCLK);
      STRBCE  = 1'b0;
   endtask

   function automatic int next_cnt(input int c);
      return (c >= 255) ? 255 : c + 1;
   endfunction

   initial begin
      repeat (3) @(negedge FASTCLK);
      check("rst_dev_strb", {22'd0, DEV_STRB}, 32'd0);
      check("rst_cmd", {22'd0, CMD}, 32'd0);
      check("rst_wr_b", {31'd0, WR_B}, 32'd1);
      check("rst_dtack_b", {31'd0, DTACK_B}, 32'd1);
      check("rst_berr_b", {31'd0, BERR_B}, 32'd1);
      check("rst_busy", {31'd0, BUSY}, 32'd0);
      check("rst_errcnt", {24'd0, ERRCNT}, 32'd0);
      RST_B  = 1'b1;
      mon_en = 1'b1;
      to_edge(9);

      // Write cycle to device 3, ack after three WAIT edges.
      e = cyc + 1;
      push(EV_STRB, e + 1, {11'd0, 1'b0, 10'h155, 10'h008});
      push(EV_DTACK, e + 5, 32'd0);
      push(EV_DTACK, e + 11, 32'd1);
      drive_start(10'h008, 10'h155, 1'b0);
      to_edge(e + 1);
      STRBCE = 1'b1; DEVICE = 10'h010; COMMAND = 10'h3FF; WRITE_B = 1'b1;   // ignored: not idle
      @(negedge FASTCLK);
      STRBCE = 1'b0;
      to_edge(e + 3);
      DEV_ACK = 10'h008;
      to_edge(e + 4);
      DEV_ACK = 10'd0;
      to_edge(e + 6);
      check("cmd_hold", {22'd0, CMD}, 32'h155);
      check("wr_b_hold", {31'd0, WR_B}, 32'd0);
      check("busy_ack", {31'd0, BUSY}, 32'd1);
      to_edge(e + 9);
      STROBE = 1'b0;
      to_edge(e + 12);
      check("busy_idle", {31'd0, BUSY}, 32'd0);

      // Timeout on device 0.
      e = cyc + 1;
      cnt_model = next_cnt(cnt_model);
      push(EV_STRB, e + 1, {11'd0, 1'b1, 10'h0AA, 10'h001});
      push(EV_CNT, e + 5, cnt_model);
      push(EV_BERR, e + 6, 32'd0);
      push(EV_BERR, e + 10, 32'd1);
      drive_start(10'h001, 10'h0AA, 1'b1);
      to_edge(e + 8);
      STROBE = 1'b0;
      to_edge(e + 11);

      // Unmapped device: immediate bus error, no start pulse.
      e = cyc + 1;
      cnt_model = next_cnt(cnt_model);
      push(EV_CNT, e, cnt_model);
      push(EV_BERR, e + 1, 32'd0);
      push(EV_BERR, e + 4, 32'd1);
      drive_start(10'h000, 10'h123, 1'b1);
      to_edge(e + 2);
      STROBE = 1'b0;
      to_edge(e + 5);

      // Wrong-device acknowledge is ignored; cycle times out.
      DEV_ACK = 10'h004;
      e = cyc + 1;
      cnt_model = next_cnt(cnt_model);
      push(EV_STRB, e + 1, {11'd0, 1'b0, 10'h0F0, 10'h020});
      push(EV_CNT, e + 5, cnt_model);
      push(EV_BERR, e + 6, 32'd0);
      push(EV_BERR, e + 9, 32'd1);
      drive_start(10'h020, 10'h0F0, 1'b0);
      to_edge(e + 7);
      STROBE  = 1'b0;
      DEV_ACK = 10'd0;
      to_edge(e + 10);

      // Acknowledge on the timeout edge: acknowledge wins.
      e = cyc + 1;
      push(EV_STRB, e + 1, {11'd0, 1'b1, 10'h00F, 10'h020});
      push(EV_DTACK, e + 6, 32'd0);
      push(EV_DTACK, e + 9, 32'd1);
      drive_start(10'h020, 10'h00F, 1'b1);
      to_edge(e + 4);
      DEV_ACK = 10'h020;
      to_edge(e + 5);
      DEV_ACK = 10'd0;
      to_edge(e + 7);
      STROBE = 1'b0;
      to_edge(e + 10);

      // Master abort in WAIT with a same-edge acknowledge.
      e = cyc + 1;
      cnt_model = next_cnt(cnt_model);
      push(EV_STRB, e + 1, {11'd0, 1'b0, 10'h2AA, 10'h004});
      push(EV_CNT, e + 3, cnt_model);
      drive_start(10'h004, 10'h2AA, 1'b0);
      to_edge(e + 2);
      STROBE  = 1'b0;
      DEV_ACK = 10'h004;
      to_edge(e + 3);
      DEV_ACK = 10'd0;
      check("busy_abort", {31'd0, BUSY}, 32'd0);
      to_edge(e + 6);

      // STRBCE while the clock manager is not ready: no response at all.
      VMEREADY = 1'b0;
      e = cyc + 1;
      drive_start(10'h008, 10'h3C3, 1'b1);
      to_edge(e + 2);
      check("gate_busy", {31'd0, BUSY}, 32'd0);
      check("gate_cmd", {22'd0, CMD}, 32'h2AA);
      check("gate_wr_b", {31'd0, WR_B}, 32'd0);
      STROBE   = 1'b0;
      VMEREADY = 1'b1;
      to_edge(e + 4);

      // 300 unmapped cycles: counter saturates at 8'hFF.
      for (int i = 0; i < 300; i++) begin
         e = cyc + 1;
         if (cnt_model < 255) begin
            cnt_model = next_cnt(cnt_model);
            push(EV_CNT, e, cnt_model);
         end
         push(EV_BERR, e + 1, 32'd0);
         push(EV_BERR, e + 3, 32'd1);
         drive_start(10'h000, 10'h001, 1'b1);
         to_edge(e + 1);
         STROBE = 1'b0;
         to_edge(e + 3);
      end
      check("errcnt_sat", {24'd0, ERRCNT}, 32'hFF);

      // Reset while in ACK: outputs return to reset values without a clock edge.
      e = cyc + 1;
      push(EV_STRB, e + 1, {11'd0, 1'b1, 10'h111, 10'h001});
      push(EV_DTACK, e + 3, 32'd0);
      push(EV_DTACK, e + 5, 32'd1);
      push(EV_CNT, e + 5, 32'd0);
      drive_start(10'h001, 10'h111, 1'b1);
      to_edge(e + 1);
      DEV_ACK = 10'h001;
      to_edge(e + 2);
      DEV_ACK = 10'd0;
      to_edge(e + 4);
      check("pre_rst_dtack_b", {31'd0, DTACK_B}, 32'd0);
      #2;
      RST_B = 1'b0;
      #1;
      check("async_dtack_b", {31'd0, DTACK_B}, 32'd1);
      check("async_busy", {31'd0, BUSY}, 32'd0);
      check("async_errcnt", {24'd0, ERRCNT}, 32'd0);
      check("async_berr_b", {31'd0, BERR_B}, 32'd1);
      check("async_cmd", {22'd0, CMD}, 32'd0);
      to_edge(e + 6);
      STROBE = 1'b0;
      to_edge(e + 7);
      RST_B = 1'b1;
      to_edge(e + 10);

      check("scoreboard_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vme_dtack_ctrl.md
Name: vme_dtack_ctrl

Overview:
- Downstream of the VME address/strobe decoder; consumes its synchronised STROBE, STRBCE, one-hot DEVICE and COMMAND outputs.
- Issues a one-cycle start pulse to the addressed device and waits for that device's acknowledge.
- Drives VME DTACK_B on acknowledge, or VME BERR_B on timeout or an unmapped device.
- Holds the bus response until the master's data strobe (STROBE) drops, and counts failed cycles for diagnostics.

Parameters:
TIMEOUT, 64, number of FASTCLK cycles allowed between DEV_STRB and DEV_ACK before a bus error; legal range 2..255.
ERRW, 8, width of the saturating error counter.

Ports:
FASTCLK  input  1  system clock, rising edge.
RST_B  input  1  asynchronous active-low reset.
VMEREADY  input  1  clock manager locked; cycles start only when high.
STROBE  input  1  synchronised VME data strobe (high = cycle active).
STRBCE  input  1  one-cycle pulse marking cycle start.
DEVICE  input  10  one-hot device select (all-zero = unmapped).
COMMAND  input  10  device command field.
WRITE_B  input  1  VME direction (low = write).
DEV_ACK  input  10  per-device done; only the latched device's bit is honoured.
DEV_STRB  output  10  one-cycle start pulse to the latched device.
CMD  output  10  latched COMMAND, stable from DEV_STRB until return to IDLE.
WR_B  output  1  latched WRITE_B, same stability as CMD.
DTACK_B  output  1  VME data acknowledge, active low.
BERR_B  output  1  VME bus error, active low.
BUSY  output  1  high in any state other than IDLE.
ERRCNT  output  ERRW  saturating count of failed cycles.

Behaviour:
- All outputs registered. Clock: FASTCLK. Reset: RST_B, asynchronous, active-low.
- Reset values: DEV_STRB=0, CMD=0, WR_B=1, DTACK_B=1, BERR_B=1, BUSY=0, ERRCNT=0, state IDLE, timer 0.
- States: IDLE, ISSUE, WAIT, ACK, ERR.
- IDLE:
  - On STRBCE=1 and VMEREADY=1: latch DEVICE into dev_l, COMMAND into CMD, WRITE_B into WR_B.
  - If DEVICE==0, go to ERR; else go to ISSUE.
  - STRBCE with VMEREADY=0 is ignored: no response, no count.
- ISSUE:
  - DEV_STRB=dev_l for exactly this one cycle; timer cleared.
  - Next state WAIT.
  - Latency: STRBCE sampled at edge k gives DEV_STRB high from edge k+1 to k+2.
- WAIT:
  - Timer increments every cycle.
  - If |(DEV_ACK & dev_l), go to ACK.
  - Else if timer reaches TIMEOUT-1, go to ERR.
  - If ACK and timeout occur on the same cycle, ACK wins.
  - Latency: DEV_ACK sampled at edge m gives DTACK_B low from edge m+1.
  - Non-latched DEV_ACK bits are ignored.
- ACK: DTACK_B=0 held while STROBE=1. On STROBE=0, go to IDLE; DTACK_B returns high on the next edge.
- ERR:
  - On entry, ERRCNT increments by 1, saturating at all-ones (no wrap).
  - BERR_B=0 held while STROBE=1. On STROBE=0, go to IDLE; BERR_B returns high.
- Master abort: STROBE=0 while in ISSUE or WAIT sends the block to IDLE without DTACK or BERR and increments ERRCNT (saturating). A pending DEV_ACK on that same edge is discarded.
- STRBCE while not IDLE is ignored; a new cycle needs a return to IDLE first.
- DTACK_B and BERR_B are never both low. Neither is asserted outside ACK/ERR.
- CMD and WR_B keep their last values in IDLE. They update only on an accepted STRBCE.
- RST_B low in any state forces the reset values immediately; a cycle in progress is abandoned silently.
- Timer width is 8 bits; timer only counts in WAIT.
- BUSY=0 only in IDLE.

Test Plan:
- Write cycle to device 3:
  - Stimulus: VMEREADY=1, DEVICE=10'h008, COMMAND=10'h155, WRITE_B=0, STRBCE at edge 10, DEV_ACK[3]=1 at edge 14, STROBE low at edge 20.
  - Expect: DEV_STRB=10'h008 for one cycle at edge 11; CMD=10'h155 and WR_B=0; DTACK_B low from edge 15 to edge 21; ERRCNT=0.
- Timeout, TIMEOUT=4:
  - Stimulus: DEVICE=10'h001, no DEV_ACK.
  - Expect: BERR_B low 5 edges after DEV_STRB, DTACK_B stays 1, ERRCNT=1; BERR_B releases one edge after STROBE drops.
- Unmapped device:
  - Stimulus: DEVICE=0 with STRBCE.
  - Expect: BERR_B low at the next edge, no DEV_STRB pulse, ERRCNT increments.
- Wrong-device ack and simultaneity:
  - Stimulus: latched device 5 while only DEV_ACK[2]=1.
  - Expect: no DTACK, and the cycle times out.
  - Separate run: DEV_ACK[5] on the timeout cycle; expect DTACK_B=0 and BERR_B=1.
- Abort and gating:
  - Stimulus: STROBE drops in WAIT.
  - Expect: IDLE, no DTACK_B/BERR_B, ERRCNT+1.
  - STRBCE with VMEREADY=0: no response.
  - Force 300 errors with ERRW=8: ERRCNT holds at 8'hFF.
- Reset mid-cycle:
  - Stimulus: assert RST_B while in ACK.
  - Expect: DTACK_B=1, BUSY=0 and ERRCNT=0 immediately, without waiting for a clock edge.
